password_controller: RTL



---
 rtl/password_controller_if.sv | 21 ++
 rtl/password_controller.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/password_controller_if.sv
// rtl/password_controller_if.sv - keypad/state-manager signal bundle for password_controller
interface password_controller_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic [2:0] state;
    logic       correct;
    logic [3:0] digit_count;
    logic       pw_updated;
    logic       lock_active;
    logic       unlock_req;

    modport master (
        output key_valid, key_code, state,
        input  correct, digit_count, pw_updated, lock_active, unlock_req
    );

    modport slave (
        input  key_valid, key_code, state,
        output correct, digit_count, pw_updated, lock_active, unlock_req
    );
endinterface

// File: rtl/password_controller.sv
// rtl/password_controller.sv - keypad entry buffer, password compare/commit and lockout timer
module password_controller #(
    parameter int MAX_DIGITS  = 8,
    parameter int MIN_DIGITS  = 4,
    parameter int LOCK_CYCLES = 1000
) (
    input logic                  clk,
    input logic                  rst,
    password_controller_if.slave bus
);

    localparam logic [2:0] ST_OFF  = 3'b000;
    localparam logic [2:0] ST_ON   = 3'b001;
    localparam logic [2:0] ST_W1   = 3'b010;
    localparam logic [2:0] ST_W2   = 3'b011;
    localparam logic [2:0] ST_RST  = 3'b101;
    localparam logic [2:0] ST_LOCK = 3'b111;

    localparam logic [3:0]  KEY_CLEAR = 4'hC;
    localparam logic [3:0]  MAX_CNT   = 4'(MAX_DIGITS);
    localparam logic [3:0]  MIN_CNT   = 4'(MIN_DIGITS);
    localparam logic [31:0] LOCK_LOAD = 32'(LOCK_CYCLES);

    logic [3:0]  entry     [MAX_DIGITS];
    logic [3:0]  entry_nxt [MAX_DIGITS];
    logic [3:0]  pw        [MAX_DIGITS];
    logic [3:0]  count, count_nxt;
    logic [3:0]  pw_len;
    logic [2:0]  prev_state;
    logic [31:0] lock_cnt;
    logic        correct_r, correct_nxt;
    logic        pw_updated_r, lock_active_r, unlock_req_r;
    logic        digit_ok, match;

    assign bus.correct     = correct_r;
    assign bus.digit_count = count;
    assign bus.pw_updated  = pw_updated_r;
    assign bus.lock_active = lock_active_r;
    assign bus.unlock_req  = unlock_req_r;

    // Next buffer contents and the match flag derived from them
    always_comb begin
        for (int i = 0; i < MAX_DIGITS; i++) begin
            entry_nxt[i] = entry[i];
        end
        count_nxt   = count;
        match       = 1'b1;
        correct_nxt = 1'b0;
        digit_ok    = (bus.state == ST_ON) || (bus.state == ST_W1) ||
                      (bus.state == ST_W2) || (bus.state == ST_RST);

        if (bus.state != prev_state) begin
            // A state change wins over any keypress in the same cycle
            for (int i = 0; i < MAX_DIGITS; i++) begin
                entry_nxt[i] = 4'd0;
            end
            count_nxt = 4'd0;
        end else if (bus.key_valid) begin
            if ((bus.key_code <= 4'd9) && digit_ok && (count < MAX_CNT)) begin
                for (int i = 0; i < MAX_DIGITS; i++) begin
                    if (4'(i) == count) begin
                        entry_nxt[i] = bus.key_code;
                    end
                end
                count_nxt = count + 4'd1;
            end else if (bus.key_code == KEY_CLEAR) begin
                for (int i = 0; i < MAX_DIGITS; i++) begin
                    entry_nxt[i] = 4'd0;
                end
                count_nxt = 4'd0;
            end
        end

        if (count_nxt != pw_len) begin
            match = 1'b0;
        end
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if ((4'(i) < pw_len) && (entry_nxt[i] != pw[i])) begin
                match = 1'b0;
            end
        end

        case (bus.state)
            ST_ON, ST_W1, ST_W2: correct_nxt = match;
            ST_RST:              correct_nxt = (count_nxt >= MIN_CNT);
            default:             correct_nxt = 1'b0;
        endcase
    end

    // Buffer, password commit and lockout timer state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_DIGITS; i++) begin
                entry[i] <= 4'd0;
                pw[i]    <= 4'd0;
            end
            count         <= 4'd0;
            pw_len        <= 4'd4;
            prev_state    <= ST_OFF;
            lock_cnt      <= 32'd0;
            correct_r     <= 1'b0;
            pw_updated_r  <= 1'b0;
            lock_active_r <= 1'b0;
            unlock_req_r  <= 1'b0;
        end else begin
            prev_state <= bus.state;
            for (int i = 0; i < MAX_DIGITS; i++) begin
                entry[i] <= entry_nxt[i];
            end
            count     <= count_nxt;
            correct_r <= correct_nxt;

            // Commit uses the buffer as it stood before the state change clears it
            pw_updated_r <= 1'b0;
            if ((prev_state == ST_RST) && (bus.state == ST_OFF) && (count >= MIN_CNT)) begin
                for (int i = 0; i < MAX_DIGITS; i++) begin
                    pw[i] <= entry[i];
                end
                pw_len       <= count;
                pw_updated_r <= 1'b1;
            end

            unlock_req_r <= 1'b0;
            if (bus.state != ST_LOCK) begin
                lock_cnt      <= 32'd0;
                lock_active_r <= 1'b0;
            end else if (prev_state != ST_LOCK) begin
                lock_cnt      <= LOCK_LOAD;
                lock_active_r <= 1'b1;
            end else if (lock_active_r) begin
                lock_cnt <= lock_cnt - 32'd1;
                if (lock_cnt == 32'd1) begin
                    lock_active_r <= 1'b0;
                    unlock_req_r  <= 1'b1;
                end
            end
        end
    end

endmodule
